// File: rtl/camo_cell_array_kl.sv
// Array of key-configurable 2-input cells (NAND/NOR/XOR per 2-bit key slice).
// Serial shadow-key load with atomic commit to the active key; registered evaluation.
module camo_cell_array_kl #(
    parameter int unsigned NUM_CELLS = 8,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   key_start,
    input  logic                                   key_bit,
    input  logic                                   key_bit_vld,
    input  logic                                   key_commit,
    input  logic                                   in_vld,
    input  logic [NUM_CELLS-1:0]                   in_a,
    input  logic [NUM_CELLS-1:0]                   in_b,
    output logic                                   out_vld,
    output logic [NUM_CELLS-1:0]                   out_y,
    output logic                                   key_active,
    output logic [$clog2(2*NUM_CELLS+1)-1:0]       key_cnt,
    output logic                                   key_err
);

    localparam int unsigned KEY_W = 2 * NUM_CELLS;
    localparam int unsigned CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] KEY_FULL = CNT_W'(KEY_W);

    typedef enum logic [1:0] {
        S_LOCKED = 2'd0,
        S_LOAD   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_W-1:0]     shadow_q, shadow_d;
    logic [KEY_W-1:0]     active_q, active_d;
    logic [CNT_W-1:0]     key_cnt_q, key_cnt_d;
    logic                 key_active_q, key_active_d;
    logic                 key_err_q, key_err_d;
    logic                 out_vld_q, out_vld_d;
    logic [NUM_CELLS-1:0] out_y_q, out_y_d;

    logic                 pipe_vld;
    logic [NUM_CELLS-1:0] pipe_y;
    logic [NUM_CELLS-1:0] samp_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOCKED;
            shadow_q     <= '0;
            active_q     <= '0;
            key_cnt_q    <= '0;
            key_active_q <= 1'b0;
            key_err_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            key_cnt_q    <= key_cnt_d;
            key_active_q <= key_active_d;
            key_err_q    <= key_err_d;
            out_vld_q    <= out_vld_d;
            out_y_q      <= out_y_d;
        end
    end

    // Key-management FSM; key_start has priority over bits and commits.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        key_cnt_d    = key_cnt_q;
        key_active_d = key_active_q;
        key_err_d    = 1'b0;

        case (state_q)
            S_LOCKED: begin
                if (key_start) begin
                    state_d   = S_LOAD;
                    key_cnt_d = '0;
                end else if (key_commit) begin
                    key_err_d = 1'b1;
                end
            end

            S_LOAD: begin
                if (key_start) begin
                    key_cnt_d = '0;
                end else begin
                    if (key_bit_vld) begin
                        if (key_cnt_q < KEY_FULL) begin
                            for (int unsigned i = 0; i < KEY_W; i++) begin
                                if (key_cnt_q == CNT_W'(i)) begin
                                    shadow_d[i] = key_bit;
                                end
                            end
                            key_cnt_d = key_cnt_q + 1'b1;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    // Commit is judged on the count before this cycle's bit lands.
                    if (key_commit) begin
                        if (key_cnt_q == KEY_FULL) begin
                            active_d     = shadow_q;
                            key_active_d = 1'b1;
                            state_d      = S_ACTIVE;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                end
            end

            S_ACTIVE: begin
                if (key_start) begin
                    state_d   = S_LOAD;
                    key_cnt_d = '0;
                end
            end

            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    always_comb begin
        samp_y = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (active_q[2*i]) begin
                samp_y[i] = in_a[i] ^ in_b[i];
            end else if (active_q[2*i+1]) begin
                samp_y[i] = ~(in_a[i] | in_b[i]);
            end else begin
                samp_y[i] = ~(in_a[i] & in_b[i]);
            end
        end
        if (!key_active_q) begin
            samp_y = '0;
        end
    end

    generate
        if (LATENCY >= 2) begin : g_lat2
            logic                 mid_vld_q, mid_vld_d;
            logic [NUM_CELLS-1:0] mid_y_q, mid_y_d;

            always_comb begin
                mid_vld_d = in_vld;
                mid_y_d   = in_vld ? samp_y : mid_y_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mid_vld_q <= 1'b0;
                    mid_y_q   <= '0;
                end else begin
                    mid_vld_q <= mid_vld_d;
                    mid_y_q   <= mid_y_d;
                end
            end

            assign pipe_vld = mid_vld_q;
            assign pipe_y   = mid_y_q;
        end else begin : g_lat1
            assign pipe_vld = in_vld;
            assign pipe_y   = samp_y;
        end
    endgenerate

    always_comb begin
        out_vld_d = pipe_vld;
        out_y_d   = pipe_vld ? pipe_y : out_y_q;
    end

    assign out_vld    = out_vld_q;
    assign out_y      = out_y_q;
    assign key_active = key_active_q;
    assign key_cnt    = key_cnt_q;
    assign key_err    = key_err_q;

endmodule

// File: tb/tb_camo_cell_array_kl.sv
// Scoreboard bench: LATENCY=1 and LATENCY=2 instances share stimulus and a
// behavioural key/cell model; a negedge monitor checks every cycle.
module tb_camo_cell_array_kl;

    localparam int N = 4;
    localparam int KW = 2 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_start = 1'b0, key_bit = 1'b0, key_bit_vld = 1'b0, key_commit = 1'b0;
    logic in_vld = 1'b0;
    logic [N-1:0] in_a = '0, in_b = '0;

    logic         vld1, vld2, kact1, kact2, kerr1, kerr2;
    logic [N-1:0] y1, y2;
    logic [3:0]   kcnt1, kcnt2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_loading = 0;
    bit         m_kact    = 0;
    bit         m_err     = 0;
    int         m_cnt     = 0;
    bit [KW-1:0] m_shadow = '0;
    bit [KW-1:0] m_active = '0;
    logic [N-1:0] q1[$];
    logic [N-1:0] q2[$];
    logic [N-1:0] last1 = '0, last2 = '0;

    always #5 clk = ~clk;

    camo_cell_array_kl #(.NUM_CELLS(N), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .key_start(key_start), .key_bit(key_bit),
        .key_bit_vld(key_bit_vld), .key_commit(key_commit), .in_vld(in_vld),
        .in_a(in_a), .in_b(in_b), .out_vld(vld1), .out_y(y1),
        .key_active(kact1), .key_cnt(kcnt1), .key_err(kerr1)
    );

    camo_cell_array_kl #(.NUM_CELLS(N), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .key_start(key_start), .key_bit(key_bit),
        .key_bit_vld(key_bit_vld), .key_commit(key_commit), .in_vld(in_vld),
        .in_a(in_a), .in_b(in_b), .out_vld(vld2), .out_y(y2),
        .key_active(kact2), .key_cnt(kcnt2), .key_err(kerr2)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] cell_eval(input bit [KW-1:0] k, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            case ({k[2*i+1], k[2*i]})
                2'b01, 2'b11: r[i] = a[i] ^ b[i];
                2'b00:        r[i] = !(a[i] && b[i]);
                default:      r[i] = !(a[i] || b[i]);
            endcase
        end
        return r;
    endfunction

    // One clock of stimulus; the model is advanced to the state after the coming edge.
    task automatic cyc(input logic ks, input logic kb, input logic kbv, input logic kc,
                       input logic iv, input logic [N-1:0] a, input logic [N-1:0] b);
        bit commit_ok;
        @(negedge clk);
        #1;
        key_start = ks; key_bit = kb; key_bit_vld = kbv; key_commit = kc;
        in_vld = iv; in_a = a; in_b = b;

        if (iv) begin
            logic [N-1:0] e;
            e = m_kact ? cell_eval(m_active, a, b) : '0;
            q1.push_back(e);
            q2.push_back(e);
        end
        m_err = 0;
        if (ks) begin
            m_loading = 1;
            m_cnt = 0;
        end else if (m_loading) begin
            commit_ok = kc && (m_cnt == KW);
            if (kc && m_cnt != KW) m_err = 1;
            if (kbv) begin
                if (m_cnt < KW) begin
                    m_shadow[m_cnt] = kb;
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (commit_ok) begin
                m_active  = m_shadow;
                m_kact    = 1;
                m_loading = 0;
            end
        end else if (kc && !m_kact) begin
            m_err = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic stream(input int n, input logic [N-1:0] a, input logic [N-1:0] b);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, a, b);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        rst = 1'b1;
        key_start = 0; key_bit = 0; key_bit_vld = 0; key_commit = 0;
        in_vld = 0; in_a = '0; in_b = '0;
        #1;
        check("rst_vld1", vld1, 0);
        check("rst_vld2", vld2, 0);
        q1.delete(); q2.delete();
        last1 = '0; last2 = '0;
        m_loading = 0; m_kact = 0; m_err = 0; m_cnt = 0;
        m_shadow = '0; m_active = '0;
        repeat (hold) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_bits(input bit [KW-1:0] k, input int n, input logic iv,
                             input logic [N-1:0] a, input logic [N-1:0] b);
        for (int i = 0; i < n; i++) cyc(0, k[i], 1, 0, iv, a, b);
    endtask

    always @(negedge clk) begin
        check("key_cnt1", kcnt1, m_cnt);
        check("key_cnt2", kcnt2, m_cnt);
        check("key_err1", kerr1, m_err);
        check("key_err2", kerr2, m_err);
        check("key_act1", kact1, m_kact);
        check("key_act2", kact2, m_kact);
        if (vld1) begin
            if (q1.size() == 0) check("spurious_vld1", 1, 0);
            else begin
                last1 = q1.pop_front();
                check("out_y1", y1, last1);
            end
        end else check("hold_y1", y1, last1);
        if (vld2) begin
            if (q2.size() == 0) check("spurious_vld2", 1, 0);
            else begin
                last2 = q2.pop_front();
                check("out_y2", y2, last2);
            end
        end else check("hold_y2", y2, last2);
    end

    initial begin
        bit [KW-1:0] k;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        // Evaluation before any key: result forced to zero
        cyc(0, 0, 0, 0, 1, 4'hF, 4'h0);
        idle(3);

        // Full load XOR/NAND/NOR/XOR then commit and evaluate
        cyc(1, 0, 0, 0, 0, '0, '0);
        load_bits(8'b1110_0001, 8, 0, '0, '0);
        cyc(0, 0, 0, 1, 0, '0, '0);
        cyc(0, 0, 0, 0, 1, 4'b1100, 4'b1010);
        idle(3);

        // Short commit is rejected, completed load is accepted
        do_reset(2);
        cyc(1, 0, 0, 0, 0, '0, '0);
        load_bits(8'b1110_0001, 5, 0, '0, '0);
        cyc(0, 0, 0, 1, 0, '0, '0);
        idle(2);
        for (int i = 5; i < 8; i++) cyc(0, 1'(i > 5), 1, 0, 0, '0, '0);
        cyc(0, 0, 0, 1, 0, '0, '0);
        idle(2);

        // Reload to all-NAND while streaming ones, then stream zeros
        cyc(1, 0, 0, 0, 1, 4'hF, 4'hF);
        load_bits(8'h00, 8, 1, 4'hF, 4'hF);
        cyc(0, 0, 0, 1, 1, 4'hF, 4'hF);
        stream(2, 4'hF, 4'hF);
        stream(3, 4'h0, 4'h0);
        idle(3);

        // Back-to-back stream then reset mid-flight
        stream(4, 4'h5, 4'h3);
        do_reset(2);
        idle(3);

        // key_start with key_bit_vld, overflow bit, bit+commit at 2N-1
        cyc(1, 1, 1, 0, 0, '0, '0);
        load_bits(8'hA5, 8, 0, '0, '0);
        cyc(0, 1, 1, 0, 0, '0, '0);
        cyc(1, 0, 0, 0, 0, '0, '0);
        load_bits(8'h3C, 7, 0, '0, '0);
        cyc(0, 1, 1, 1, 0, '0, '0);
        cyc(0, 0, 0, 1, 1, 4'h9, 4'h6);
        cyc(0, 0, 0, 1, 1, 4'h9, 4'h6);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                cyc($urandom_range(39) == 0, 1'($urandom), $urandom_range(1) == 0,
                    $urandom_range(11) == 0, $urandom_range(1) == 0,
                    N'($urandom), N'($urandom));
            end
        end
        idle(4);
        check("drain_q1", q1.size(), 0);
        check("drain_q2", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
